// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC generation, single-outstanding imem requests,
// IF/ID register with stall hold buffer and redirect flush.
module fetch_unit #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_resp_valid,
   input  logic [31:0]     imem_resp_data,
   output logic            valid_IFID,
   output logic [XLEN-1:0] pc_IFID,
   output logic [XLEN-1:0] pc4_IFID,
   output logic [31:0]     instr_IFID
);

   typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_HOLD, S_DROP} state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_req_pc;
   logic [XLEN-1:0] r_hold_pc;
   logic [31:0]     r_hold_instr;
   logic            r_valid_ifid;
   logic [XLEN-1:0] r_pc_ifid;
   logic [XLEN-1:0] r_pc4_ifid;
   logic [31:0]     r_instr_ifid;

   logic [XLEN-1:0] w_redirect_pc;
   logic            w_accept;
   logic            w_load_resp;
   logic            w_load_hold;
   logic            w_capture;

   assign w_redirect_pc = redirect_pc & ~XLEN'(3);
   assign w_accept      = (r_state == S_ISSUE) && imem_req_ready;
   assign w_load_resp   = (r_state == S_WAIT) && imem_resp_valid && !stall && !redirect;
   assign w_load_hold   = (r_state == S_HOLD) && !stall && !redirect;
   assign w_capture     = (r_state == S_WAIT) && imem_resp_valid && stall && !redirect;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_ISSUE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Redirect never cancels a request already accepted, so its response must still be drained.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_ISSUE: if (imem_req_ready) w_state_next = redirect ? S_DROP : S_WAIT;
         S_WAIT: begin
            if (imem_resp_valid) begin
               w_state_next = (redirect || !stall) ? S_ISSUE : S_HOLD;
            end else if (redirect) begin
               w_state_next = S_DROP;
            end
         end
         S_HOLD:  if (redirect || !stall) w_state_next = S_ISSUE;
         S_DROP:  if (imem_resp_valid) w_state_next = S_ISSUE;
         default: w_state_next = S_ISSUE;
      endcase
   end

   always_comb begin
      imem_req_valid = (r_state == S_ISSUE);
      imem_req_addr  = r_pc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc         <= RESET_PC;
         r_req_pc     <= '0;
         r_hold_pc    <= '0;
         r_hold_instr <= '0;
      end else begin
         if (redirect) begin
            r_pc <= w_redirect_pc;
         end else if (w_accept) begin
            r_pc <= r_pc + XLEN'(4);
         end
         if (w_accept) begin
            r_req_pc <= r_pc;
         end
         if (redirect) begin
            r_hold_pc    <= '0;
            r_hold_instr <= '0;
         end else if (w_capture) begin
            r_hold_pc    <= r_req_pc;
            r_hold_instr <= imem_resp_data;
         end
      end
   end

   // Bubbles keep the last PC fields; only stall freezes the whole slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid_ifid <= 1'b0;
         r_pc_ifid    <= '0;
         r_pc4_ifid   <= '0;
         r_instr_ifid <= NOP_INSTR;
      end else if (redirect) begin
         r_valid_ifid <= 1'b0;
         r_instr_ifid <= NOP_INSTR;
      end else if (w_load_resp) begin
         r_valid_ifid <= 1'b1;
         r_pc_ifid    <= r_req_pc;
         r_pc4_ifid   <= r_req_pc + XLEN'(4);
         r_instr_ifid <= imem_resp_data;
      end else if (w_load_hold) begin
         r_valid_ifid <= 1'b1;
         r_pc_ifid    <= r_hold_pc;
         r_pc4_ifid   <= r_hold_pc + XLEN'(4);
         r_instr_ifid <= r_hold_instr;
      end else if (!stall) begin
         r_valid_ifid <= 1'b0;
         r_instr_ifid <= NOP_INSTR;
      end
   end

   assign valid_IFID = r_valid_ifid;
   assign pc_IFID    = r_pc_ifid;
   assign pc4_IFID   = r_pc4_ifid;
   assign instr_IFID = r_instr_ifid;

endmodule

// File: tb/tb_fetch_unit.sv
// Cycle-by-cycle vector bench for fetch_unit: the bench plays instruction memory
// and the hazard/EX stages, and scores request outputs and the IF/ID register.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      logic        stall;
      logic        redir;
      logic [31:0] rpc;
      logic        ready;
      logic        rv;
      logic [31:0] rdata;
      logic        ereq;
      logic [31:0] eaddr;
      logic        ev;
      logic [31:0] epc;
      logic [31:0] epc4;
      logic [31:0] einstr;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        valid_IFID;
   logic [31:0] pc_IFID;
   logic [31:0] pc4_IFID;
   logic [31:0] instr_IFID;

   int   n_checks = 0;
   int   n_errors = 0;
   vec_t sb_q[$];
   vec_t tbl[23];
   vec_t seq2[8];

   fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .stall(stall),
      .redirect(redirect),
      .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid),
      .imem_req_addr(imem_req_addr),
      .imem_req_ready(imem_req_ready),
      .imem_resp_valid(imem_resp_valid),
      .imem_resp_data(imem_resp_data),
      .valid_IFID(valid_IFID),
      .pc_IFID(pc_IFID),
      .pc4_IFID(pc4_IFID),
      .instr_IFID(instr_IFID)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rpc,
                               input logic rdy, input logic rv, input logic [31:0] rdata,
                               input logic ereq, input logic [31:0] eaddr, input logic ev,
                               input logic [31:0] epc, input logic [31:0] epc4,
                               input logic [31:0] einstr);
      vec_t v;
      v.stall = st;  v.redir = rd;  v.rpc = rpc;    v.ready = rdy;
      v.rv = rv;     v.rdata = rdata;
      v.ereq = ereq; v.eaddr = eaddr; v.ev = ev;
      v.epc = epc;   v.epc4 = epc4; v.einstr = einstr;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, ".req_valid"}, {31'b0, imem_req_valid}, 32'd1);
      chk({tag, ".req_addr"},  imem_req_addr, 32'h0);
      chk({tag, ".valid"},     {31'b0, valid_IFID}, 32'd0);
      chk({tag, ".pc"},        pc_IFID, 32'h0);
      chk({tag, ".pc4"},       pc4_IFID, 32'h0);
      chk({tag, ".instr"},     instr_IFID, NOP);
   endtask

   // Called at a falling edge: drive one cycle of inputs, score request outputs,
   // queue the IF/ID expectation and score it at the next falling edge.
   task automatic step(input vec_t v, input string tag);
      vec_t e;
      stall = v.stall; redirect = v.redir; redirect_pc = v.rpc;
      imem_req_ready = v.ready; imem_resp_valid = v.rv; imem_resp_data = v.rdata;
      #1;
      chk({tag, ".req_valid"}, {31'b0, imem_req_valid}, {31'b0, v.ereq});
      if (v.ereq) chk({tag, ".req_addr"}, imem_req_addr, v.eaddr);
      sb_q.push_back(v);
      @(negedge clk);
      e = sb_q.pop_front();
      chk({tag, ".valid"}, {31'b0, valid_IFID}, {31'b0, e.ev});
      chk({tag, ".pc"},    pc_IFID, e.epc);
      chk({tag, ".pc4"},   pc4_IFID, e.epc4);
      chk({tag, ".instr"}, instr_IFID, e.einstr);
      $display("%s: req=%b addr=%h valid=%b pc=%h pc4=%h instr=%h", tag,
               v.ereq, v.eaddr, valid_IFID, pc_IFID, pc4_IFID, instr_IFID);
   endtask

   initial begin
      // Straight-line fetch, 3-cycle stall into HOLD, redirect in WAIT with k=3,
      // redirect+stall with unaligned target, redirect with response, PC wrap.
      tbl[0]  = mk(0,0,0,            1,0,0,            1,0,            0,0,0,NOP);
      tbl[1]  = mk(0,0,0,            0,1,32'h13,       0,0,            1,0,4,32'h13);
      tbl[2]  = mk(0,0,0,            1,0,0,            1,4,            0,0,4,NOP);
      tbl[3]  = mk(0,0,0,            0,1,32'h00500093, 0,0,            1,4,8,32'h00500093);
      tbl[4]  = mk(1,0,0,            1,0,0,            1,8,            1,4,8,32'h00500093);
      tbl[5]  = mk(1,0,0,            0,1,32'h00A00113, 0,0,            1,4,8,32'h00500093);
      tbl[6]  = mk(1,0,0,            0,0,0,            0,0,            1,4,8,32'h00500093);
      tbl[7]  = mk(0,0,0,            0,0,0,            0,0,            1,8,12,32'h00A00113);
      tbl[8]  = mk(0,0,0,            1,0,0,            1,12,           0,8,12,NOP);
      tbl[9]  = mk(0,0,0,            0,0,0,            0,0,            0,8,12,NOP);
      tbl[10] = mk(0,1,32'h100,      0,0,0,            0,0,            0,8,12,NOP);
      tbl[11] = mk(0,0,0,            0,1,32'hDEADBEEF, 0,0,            0,8,12,NOP);
      tbl[12] = mk(0,0,0,            1,0,0,            1,32'h100,      0,8,12,NOP);
      tbl[13] = mk(0,0,0,            0,1,32'h11111111, 0,0,            1,32'h100,32'h104,32'h11111111);
      tbl[14] = mk(1,1,32'h203,      0,0,0,            1,32'h104,      0,32'h100,32'h104,NOP);
      tbl[15] = mk(0,0,0,            1,0,0,            1,32'h200,      0,32'h100,32'h104,NOP);
      tbl[16] = mk(0,1,32'h300,      0,1,32'h22222222, 0,0,            0,32'h100,32'h104,NOP);
      tbl[17] = mk(0,0,0,            1,0,0,            1,32'h300,      0,32'h100,32'h104,NOP);
      tbl[18] = mk(0,0,0,            0,1,32'h33333333, 0,0,            1,32'h300,32'h304,32'h33333333);
      tbl[19] = mk(0,1,32'hFFFFFFFC, 0,0,0,            1,32'h304,      0,32'h300,32'h304,NOP);
      tbl[20] = mk(0,0,0,            1,0,0,            1,32'hFFFFFFFC, 0,32'h300,32'h304,NOP);
      tbl[21] = mk(0,0,0,            0,1,32'h44444444, 0,0,            1,32'hFFFFFFFC,32'h0,32'h44444444);
      tbl[22] = mk(0,0,0,            1,0,0,            1,32'h0,        0,32'hFFFFFFFC,32'h0,NOP);

      // Redirect on an accepted request (ISSUE->DROP), then redirect out of HOLD
      // must discard the buffered instruction.
      seq2[0] = mk(0,1,32'h80,       1,0,0,            1,0,            0,0,0,NOP);
      seq2[1] = mk(0,0,0,            0,0,0,            0,0,            0,0,0,NOP);
      seq2[2] = mk(0,0,0,            0,1,32'hBAD0BAD0, 0,0,            0,0,0,NOP);
      seq2[3] = mk(0,0,0,            1,0,0,            1,32'h80,       0,0,0,NOP);
      seq2[4] = mk(1,0,0,            0,1,32'h55555555, 0,0,            0,0,0,NOP);
      seq2[5] = mk(1,1,32'h90,       0,0,0,            0,0,            0,0,0,NOP);
      seq2[6] = mk(0,0,0,            1,0,0,            1,32'h90,       0,0,0,NOP);
      seq2[7] = mk(0,0,0,            0,1,32'h66666666, 0,0,            1,32'h90,32'h94,32'h66666666);

      rst_n = 1'b0;
      drive_idle();
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst_n = 1'b1;

      for (int i = 0; i < 23; i++) step(tbl[i], $sformatf("t%0d", i));

      // Now in WAIT for address 0: asynchronous reset must act without a clock edge.
      drive_idle();
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("async_reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) step(seq2[i], $sformatf("s%0d", i));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined core. Generates the PC, issues single-outstanding requests to instruction memory, and writes the IF/ID pipeline register consumed by decode and the hazard unit. Honours the hazard unit's `stall` by freezing IF/ID and buffering one returning instruction. Honours EX-stage redirects by flushing IF/ID and discarding stale memory responses.

## Interface
- `XLEN`, 32: address/data width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `NOP_INSTR`, 32'h0000_0013: value driven on `instr_IFID` when the slot is invalid (`addi x0,x0,0`).

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `stall`  in  1  from hazard unit; 1 = hold IF/ID contents this cycle.
- `redirect`  in  1  branch/jump taken in EX; flush and refetch.
- `redirect_pc`  in  XLEN  new fetch address; bits [1:0] ignored (forced 0).
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_addr`  out  XLEN  fetch address.
- `imem_req_ready`  in  1  memory accepts request this cycle.
- `imem_resp_valid`  in  1  instruction returned this cycle (exactly one per accepted request, ≥1 cycle after acceptance).
- `imem_resp_data`  in  32  returned instruction.
- `valid_IFID`  out  1  IF/ID slot holds a real instruction.
- `pc_IFID`  out  XLEN  PC of the IF/ID instruction.
- `pc4_IFID`  out  XLEN  `pc_IFID + 4`, registered.
- `instr_IFID`  out  32  instruction bits.

## Operation
- Registers: `pc` (next fetch address), `req_pc` (address of outstanding request), one-entry hold buffer (`hold_instr`, `hold_pc`), IF/ID register, FSM.
- FSM states: ISSUE, WAIT, HOLD, DROP.
  - ISSUE: `imem_req_valid=1`, `imem_req_addr=pc`. On `imem_req_ready`: `req_pc<=pc`, `pc<=pc+4`, → WAIT.
  - WAIT: on `imem_resp_valid` with `stall=0`: IF/ID <= {1, req_pc, req_pc+4, resp_data}, → ISSUE. With `stall=1`: hold buffer <= {resp_data, req_pc}, → HOLD.
  - HOLD: `imem_req_valid=0`. When `stall=0`: IF/ID <= hold buffer (valid=1), → ISSUE.
  - DROP: response pending is stale; on `imem_resp_valid` discard data, → ISSUE.
- `imem_req_valid=0` in WAIT, HOLD, DROP (at most one outstanding request).
- IF/ID when no new instruction is written and `stall=0`: `valid_IFID<=0`, `instr_IFID<=NOP_INSTR` (bubble); `pc_IFID`/`pc4_IFID` hold.
- IF/ID when `stall=1`: all fields hold.
- Redirect (priority over stall and over every state action): `pc<=redirect_pc & ~3`; IF/ID <= bubble (`valid=0`, NOP); hold buffer discarded. Next state:
  - ISSUE with `imem_req_ready=1` → DROP; with `ready=0` → ISSUE (address changes next cycle; imem tolerates un-accepted address change).
  - WAIT with `imem_resp_valid=1` → ISSUE (response discarded); without → DROP.
  - HOLD → ISSUE. DROP → DROP (pending response still stale).
- PC arithmetic modulo 2^XLEN; `pc+4` wraps at 0xFFFF_FFFC → 0.

## Timing
- Reset (async assert, sync-style release): state=ISSUE, `pc=RESET_PC`, `req_pc=0`, hold buffer cleared, `valid_IFID=0`, `pc_IFID=0`, `pc4_IFID=0`, `instr_IFID=NOP_INSTR`. `imem_req_valid=1` with `addr=RESET_PC` in the first cycle after release. Reset mid-request: pending response is never observed as valid by this block.
- Latency: request accepted cycle T, response at T+k (k≥1) → `valid_IFID=1` from edge at end of T+k when unstalled.
- Peak throughput with k=1: one instruction per 2 cycles.
- Redirect asserted in cycle T: `valid_IFID=0` after edge T; request for `redirect_pc` at the earliest in T+1 (ISSUE path) or the cycle after the stale response.
- Outputs `imem_req_valid`/`imem_req_addr` are functions of state and `pc` only (no input-to-output combinational path).

## Test plan
- Reset, memory k=1 always ready, sequence 0x13,0x00500093,…: IF/ID shows PC 0,4,8 every 2 cycles, `pc4_IFID` = PC+4, first `valid_IFID=1` at cycle 2.
- Response at PC 8 arrives with `stall=1` for 3 cycles: IF/ID holds PC 4 data throughout, no new request issued, PC 8 instruction appears the cycle after `stall` drops.
- Redirect to 0x100 while in WAIT (k=3): stale response discarded, `valid_IFID=0` next cycle, next accepted request address = 0x100.
- Redirect and `stall` in the same cycle, plus `redirect_pc=0x203`: IF/ID becomes bubble (redirect wins), fetch address 0x200.
- Redirect coincident with `imem_resp_valid` in WAIT: data not loaded, FSM → ISSUE, no DROP cycle.
- `redirect_pc=0xFFFF_FFFC`: fetches 0xFFFF_FFFC then 0x0000_0000; assert `rst_n` low mid-WAIT: all outputs return to reset values immediately.
